// File: rtl/piso.sv
// piso: parallel-in serial-out shift register with an "all bits shifted out" flag.
// Define PISO_LSB_FIRST_EN to shift the word out LSB first instead of MSB first.
module piso #(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_shift,
  input  logic [WIDTH-1:0] in,
  output logic             qout,
  output logic             empty
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  FULL = CW'(WIDTH);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load_shift) begin
      sreg_d = in;
      cnt_d  = FULL;
    end else begin
`ifdef PISO_LSB_FIRST_EN
      sreg_d = {FILL, sreg_q[WIDTH-1:1]};
`else
      sreg_d = {sreg_q[WIDTH-2:0], FILL};
`endif
      // Shifting past the end keeps going, but the count holds at zero.
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef PISO_LSB_FIRST_EN
  assign qout = sreg_q[0];
`else
  assign qout = sreg_q[WIDTH-1];
`endif

  assign empty = (cnt_q == '0);

endmodule

// File: tb/tb_piso.sv
// Bench for piso: table-driven vectors plus hand sequences, with a scoreboard queue.
// One DUT uses FILL=0 and a second uses FILL=1; both see identical stimulus.
module tb_piso;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         loadShift = 1'b0;
  logic [W-1:0] din = '0;
  logic         q0, e0, q1, e1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso #(.WIDTH(W), .FILL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load_shift(loadShift), .in(din), .qout(q0), .empty(e0)
  );

  piso #(.WIDTH(W), .FILL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load_shift(loadShift), .in(din), .qout(q1), .empty(e1)
  );

  typedef struct {
    logic         r;
    logic         ls;
    logic [W-1:0] d;
    logic         q;
    logic         e;
    string        name;
  } vec_t;

  typedef struct {
    logic  q0;
    logic  e0;
    logic  q1;
    logic  e1;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  // Reference model: the loaded word plus how many shift edges have happened since.
  logic [W-1:0] mWord[2];
  int           mK[2];
  bit           mRst[2];
  logic         mFill[2] = '{1'b0, 1'b1};

  function automatic void modelStep(int i, logic r, logic ls, logic [W-1:0] d);
    if (r) begin
      mWord[i] = '0;
      mK[i]    = 0;
      mRst[i]  = 1'b1;
    end else if (ls) begin
      mWord[i] = d;
      mK[i]    = 0;
      mRst[i]  = 1'b0;
    end else if (mK[i] < 1000) begin
      mK[i] = mK[i] + 1;
    end
  endfunction

  function automatic logic modelQ(int i);
    if (mK[i] >= W) return mFill[i];
`ifdef PISO_LSB_FIRST_EN
    return mWord[i][mK[i]];
`else
    return mWord[i][W-1-mK[i]];
`endif
  endfunction

  function automatic logic modelE(int i);
    return mRst[i] || (mK[i] >= W);
  endfunction

  function automatic void addVec(logic r, logic ls, logic [W-1:0] d, logic q, logic e, string name);
    vec_t v;
    v.r = r; v.ls = ls; v.d = d; v.q = q; v.e = e; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_underflow: got empty queue expected an entry");
      return;
    end
    x = sb.pop_front();
    checkBit({x.name, "/dut0.qout"},  q0, x.q0);
    checkBit({x.name, "/dut0.empty"}, e0, x.e0);
    checkBit({x.name, "/dut1.qout"},  q1, x.q1);
    checkBit({x.name, "/dut1.empty"}, e1, x.e1);
  endtask

  // Drive one cycle of stimulus, push the expectation, then sample after the edge.
  task automatic applyStimulus(input logic r, input logic ls, input logic [W-1:0] d,
                               input logic tq, input logic te, input bit useTab,
                               input string name);
    exp_t x;
    bit   tabOk;
    tabOk = useTab;
`ifdef PISO_LSB_FIRST_EN
    tabOk = 1'b0;
`endif
    @(negedge clk);
    rst       = r;
    loadShift = ls;
    din       = d;
    modelStep(0, r, ls, d);
    modelStep(1, r, ls, d);
    x.name = name;
    x.q1   = modelQ(1);
    x.e1   = modelE(1);
    if (tabOk) begin
      x.q0 = tq;
      x.e0 = te;
    end else begin
      x.q0 = modelQ(0);
      x.e0 = modelE(0);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic t5q[6];
    logic t5e[6];
    logic t6q[4];

    t5q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t5e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t6q = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Reset, then idle shifting stays empty with qout low.
    addVec(1, 0, 4'b0000, 0, 1, "t1_rst");
    addVec(0, 0, 4'b0000, 0, 1, "t1_s1");
    addVec(0, 0, 4'b0000, 0, 1, "t1_s2");
    addVec(0, 0, 4'b0000, 0, 1, "t1_s3");
    // Load 1101 and shift six times.
    addVec(0, 1, 4'b1101, 1, 0, "t2_load");
    addVec(0, 0, 4'b0000, 1, 0, "t2_s1");
    addVec(0, 0, 4'b0000, 0, 0, "t2_s2");
    addVec(0, 0, 4'b0000, 1, 0, "t2_s3");
    addVec(0, 0, 4'b0000, 0, 1, "t2_s4");
    addVec(0, 0, 4'b0000, 0, 1, "t2_s5");
    addVec(0, 0, 4'b0000, 0, 1, "t2_s6");
    // Load mid-word aborts the old word.
    addVec(0, 1, 4'b1010, 1, 0, "t3_load1");
    addVec(0, 0, 4'b0000, 0, 0, "t3_s1");
    addVec(0, 0, 4'b0000, 1, 0, "t3_s2");
    addVec(0, 1, 4'b0111, 0, 0, "t3_load2");
    addVec(0, 0, 4'b0000, 1, 0, "t3_s3");
    addVec(0, 0, 4'b0000, 1, 0, "t3_s4");
    addVec(0, 0, 4'b0000, 1, 0, "t3_s5");
    addVec(0, 0, 4'b0000, 0, 1, "t3_s6");
    // Reset beats a simultaneous load.
    addVec(0, 1, 4'b1111, 1, 0, "t4_load");
    addVec(0, 0, 4'b0000, 1, 0, "t4_s1");
    addVec(1, 1, 4'b1111, 0, 1, "t4_rstload");
    addVec(0, 0, 4'b0000, 0, 1, "t4_s2");
    // Back-to-back loads, then reload exactly on the empty edge.
    addVec(0, 1, 4'b1001, 1, 0, "b_load1");
    addVec(0, 1, 4'b0110, 0, 0, "b_load2");
    addVec(0, 0, 4'b0000, 1, 0, "b_s1");
    addVec(0, 0, 4'b0000, 1, 0, "b_s2");
    addVec(0, 0, 4'b0000, 0, 0, "b_s3");
    addVec(0, 0, 4'b0000, 0, 1, "b_s4");
    addVec(0, 1, 4'b1000, 1, 0, "b_load3");
    addVec(0, 0, 4'b0000, 0, 0, "b_s5");

    $display("[TB] table phase: %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].ls, vecs[i].d, vecs[i].q, vecs[i].e, 1'b1, vecs[i].name);
    end

    // FILL=1 instance: zero word, then ones appear once the word is gone.
    applyStimulus(1, 0, 4'b0000, 0, 0, 1'b0, "t5_rst");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, (k == 0), 4'b0000, 0, 0, 1'b0, $sformatf("t5_step%0d", k));
      checkBit($sformatf("t5_fill_qout%0d", k), q1, t5q[k]);
      checkBit($sformatf("t5_fill_empty%0d", k), e1, t5e[k]);
    end

`ifdef PISO_LSB_FIRST_EN
    // LSB-first order for 1101.
    applyStimulus(1, 0, 4'b0000, 0, 0, 1'b0, "t6_rst");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, (k == 0), 4'b1101, 0, 0, 1'b0, $sformatf("t6_step%0d", k));
      checkBit($sformatf("t6_lsb_qout%0d", k), q0, t6q[k]);
    end
`endif

    // Random mix of loads, shifts and occasional resets against the model.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 15)), 0, 0, 1'b0, $sformatf("rnd%0d", n));
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
